// File: rtl/spi_adc128s_slave.sv
// SPI slave front-end for an ADC128S-style A2D model: shifts A2D_data out on MISO and a command in from MOSI.
// Optional build macro MISO_TRISTATE_EN releases MISO (1'bz) outside a frame instead of driving 0.
module spi_adc128s_slave #(
  parameter int FRAME_W     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               SS_n,
  input  logic               SCLK,
  input  logic               MOSI,
  output logic               MISO,
  input  logic [FRAME_W-1:0] A2D_data,
  output logic [FRAME_W-1:0] cmd,
  output logic               rdy
);

  localparam int CNT_W = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] ss_sync_p0;
  logic [SYNC_STAGES-1:0] sclk_sync_p0;
  logic [SYNC_STAGES-1:0] mosi_sync_p0;
  logic                   ss_hist_p1;
  logic                   sclk_hist_p1;
  logic                   ss_s;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   ss_fall;
  logic                   ss_rise;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic [FRAME_W-1:0]     tx_shft;
  logic [FRAME_W-1:0]     rx_shft;
  logic [FRAME_W-1:0]     rx_nxt;
  logic [CNT_W-1:0]       bit_cnt;
  logic [CNT_W-1:0]       cnt_nxt;

  // Stage p0: pin synchronisers; idle levels (SS_n and SCLK high) so reset creates no false edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_sync_p0   <= '1;
      sclk_sync_p0 <= '1;
      mosi_sync_p0 <= '0;
    end else begin
      ss_sync_p0   <= {ss_sync_p0[SYNC_STAGES-2:0], SS_n};
      sclk_sync_p0 <= {sclk_sync_p0[SYNC_STAGES-2:0], SCLK};
      mosi_sync_p0 <= {mosi_sync_p0[SYNC_STAGES-2:0], MOSI};
    end
  end

  assign ss_s   = ss_sync_p0[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_p0[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_p0[SYNC_STAGES-1];

  // Stage p1: history flops for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_hist_p1   <= 1'b1;
      sclk_hist_p1 <= 1'b1;
    end else begin
      ss_hist_p1   <= ss_s;
      sclk_hist_p1 <= sclk_s;
    end
  end

  assign ss_fall   = ss_hist_p1 & ~ss_s;
  assign ss_rise   = ~ss_hist_p1 & ss_s;
  assign sclk_rise = ~sclk_hist_p1 & sclk_s;
  assign sclk_fall = sclk_hist_p1 & ~sclk_s;

  // Post-rise view of the receiver, so a capture coinciding with the last rise sees that bit
  always_comb begin
    rx_nxt  = rx_shft;
    cnt_nxt = bit_cnt;
    if (sclk_rise) begin
      rx_nxt = {rx_shft[FRAME_W-2:0], mosi_s};
      if (bit_cnt != CNT_FULL) cnt_nxt = bit_cnt + CNT_W'(1);
    end
  end

  // Stage p2: frame state machine and shift registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tx_shft <= '0;
      rx_shft <= '0;
      bit_cnt <= '0;
      cmd     <= '0;
      rdy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ss_fall) begin
            state   <= SHIFT;
            tx_shft <= A2D_data;
            bit_cnt <= '0;
            rdy     <= 1'b0;
          end
        end
        SHIFT: begin
          rx_shft <= rx_nxt;
          bit_cnt <= cnt_nxt;
          // A fall before the first rise would discard the MSB before the master samples it
          if (sclk_fall && (bit_cnt != '0)) tx_shft <= {tx_shft[FRAME_W-2:0], 1'b0};
          if (ss_rise) begin
            state <= IDLE;
            if (cnt_nxt >= CNT_FULL) begin
              cmd <= rx_nxt;
              rdy <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MISO_TRISTATE_EN
  assign MISO = (state == SHIFT) ? tx_shft[FRAME_W-1] : 1'bz;
`else
  assign MISO = (state == SHIFT) ? tx_shft[FRAME_W-1] : 1'b0;
`endif

endmodule

// File: tb/tb_spi_adc128s_slave.sv
// Directed bench for spi_adc128s_slave: a bit-banged SPI master exchanges frames and checks MISO, cmd and rdy.
module tb_spi_adc128s_slave;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic [15:0] A2D_data = 16'h0000;
  logic [15:0] cmd;
  logic        rdy;

  int checks = 0;
  int errors = 0;
  int clr_lat;
  int rdy_rises = 0;
  logic rdy_q = 1'b0;
  logic miso_idle;
  logic [31:0] rx_word;

  spi_adc128s_slave #(.FRAME_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .A2D_data(A2D_data), .cmd(cmd), .rdy(rdy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rdy_q <= rdy;
    if (rdy && !rdy_q) rdy_rises <= rdy_rises + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Master: SS_n low, nbits clocks (MOSI changes on fall, MISO sampled at rise), optional SS_n high.
  task automatic xfer(input logic [31:0] mosi_word, input int nbits, input bit simult,
                      input bit keep_low, output logic [31:0] miso_word);
    miso_word = '0;
    clr_lat = -1;
    @(negedge clk);
    SS_n = 1'b0;
    for (int j = 0; j < HALF; j++) begin
      @(negedge clk);
      if (rdy === 1'b0 && clr_lat < 0) clr_lat = j + 1;
    end
    A2D_data = ~A2D_data;
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = mosi_word[nbits-1-i];
      repeat (HALF) @(negedge clk);
      miso_word = {miso_word[30:0], MISO};
      SCLK = 1'b1;
      if (simult && i == nbits - 1) SS_n = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    if (!keep_low) begin
      SS_n = 1'b1;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (cmd !== 16'h0000) begin errors++; $display("FAIL reset_cmd got %h want %h", cmd, 16'h0000); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b want 0", rdy); end
    checks++; if (MISO !== miso_idle) begin errors++; $display("FAIL reset_miso got %b want %b", MISO, miso_idle); end
    rst = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic test_basic();
    A2D_data = 16'h0C00;
    xfer(32'h0000, 16, 1'b0, 1'b0, rx_word);
    checks++; if (rx_word[15:0] !== 16'h0C00) begin errors++; $display("FAIL basic_miso got %h want 0c00", rx_word[15:0]); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL basic_rdy got %b want 1", rdy); end
    checks++; if (cmd !== 16'h0000) begin errors++; $display("FAIL basic_cmd got %h want 0000", cmd); end
    checks++; if (MISO !== miso_idle) begin errors++; $display("FAIL basic_miso_idle got %b want %b", MISO, miso_idle); end
  endtask

  task automatic test_capture_rdy_clear();
    int rises0;
    rises0 = rdy_rises;
    A2D_data = 16'h0BF3;
    xfer(32'h1800, 16, 1'b0, 1'b0, rx_word);
    checks++; if (clr_lat < 1 || clr_lat > 4) begin errors++; $display("FAIL rdy_clear_latency got %0d want 1..4", clr_lat); end
    checks++; if (rx_word[15:0] !== 16'h0BF3) begin errors++; $display("FAIL capture_miso got %h want 0bf3", rx_word[15:0]); end
    checks++; if (cmd !== 16'h1800) begin errors++; $display("FAIL capture_cmd got %h want 1800", cmd); end
    checks++; if (cmd[13:11] !== 3'b011) begin errors++; $display("FAIL capture_chan got %b want 011", cmd[13:11]); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL capture_rdy got %b want 1", rdy); end
    checks++; if (rdy_rises - rises0 !== 1) begin errors++; $display("FAIL capture_rdy_rises got %0d want 1", rdy_rises - rises0); end
  endtask

  task automatic test_idle_sclk();
    MOSI = 1'b1;
    for (int i = 0; i < 4; i++) begin
      SCLK = 1'b0; repeat (HALF) @(negedge clk);
      SCLK = 1'b1; repeat (HALF) @(negedge clk);
    end
    checks++; if (cmd !== 16'h1800) begin errors++; $display("FAIL idle_sclk_cmd got %h want 1800", cmd); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL idle_sclk_rdy got %b want 1", rdy); end
    checks++; if (MISO !== miso_idle) begin errors++; $display("FAIL idle_sclk_miso got %b want %b", MISO, miso_idle); end
  endtask

  task automatic test_overlength();
    A2D_data = 16'h8001;
    xfer(32'h000F_1234, 20, 1'b0, 1'b0, rx_word);
    checks++; if (rx_word[19:0] !== 20'h80010) begin errors++; $display("FAIL over_miso got %h want 80010", rx_word[19:0]); end
    checks++; if (cmd !== 16'h1234) begin errors++; $display("FAIL over_cmd got %h want 1234", cmd); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL over_rdy got %b want 1", rdy); end
  endtask

  task automatic test_simultaneous();
    A2D_data = 16'h3C3C;
    xfer(32'h5A5B, 16, 1'b1, 1'b0, rx_word);
    checks++; if (rx_word[15:0] !== 16'h3C3C) begin errors++; $display("FAIL simult_miso got %h want 3c3c", rx_word[15:0]); end
    checks++; if (cmd !== 16'h5A5B) begin errors++; $display("FAIL simult_cmd got %h want 5a5b", cmd); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL simult_rdy got %b want 1", rdy); end
  endtask

  task automatic test_abort();
    A2D_data = 16'h7777;
    xfer(32'h00FF, 8, 1'b0, 1'b0, rx_word);
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL abort_rdy got %b want 0", rdy); end
    checks++; if (cmd !== 16'h5A5B) begin errors++; $display("FAIL abort_cmd got %h want 5a5b", cmd); end
  endtask

  task automatic test_reset_mid_frame();
    A2D_data = 16'hFFFF;
    xfer(32'h001F, 5, 1'b0, 1'b1, rx_word);
    @(negedge clk);
    rst  = 1'b1;
    SS_n = 1'b1;
    SCLK = 1'b1;
    @(negedge clk);
    checks++; if (cmd !== 16'h0000) begin errors++; $display("FAIL midrst_cmd got %h want 0000", cmd); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL midrst_rdy got %b want 0", rdy); end
    checks++; if (MISO !== miso_idle) begin errors++; $display("FAIL midrst_miso got %b want %b", MISO, miso_idle); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (HALF) @(negedge clk);
    A2D_data = 16'h1234;
    xfer(32'hABCD, 16, 1'b0, 1'b0, rx_word);
    checks++; if (rx_word[15:0] !== 16'h1234) begin errors++; $display("FAIL postrst_miso got %h want 1234", rx_word[15:0]); end
    checks++; if (cmd !== 16'hABCD) begin errors++; $display("FAIL postrst_cmd got %h want abcd", cmd); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL postrst_rdy got %b want 1", rdy); end
  endtask

  initial begin
`ifdef MISO_TRISTATE_EN
    miso_idle = 1'bz;
`else
    miso_idle = 1'b0;
`endif
    test_reset();
    test_basic();
    test_capture_rdy_clear();
    test_idle_sclk();
    test_overlength();
    test_simultaneous();
    test_abort();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
